// File: rtl/uart_controller_pkg.sv
// uart_controller_pkg: register map, status bit positions, FSM state codes and baud divisor helper
package uart_controller_pkg;
  localparam logic UART_REG_DATA   = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;
  localparam int UART_STAT_TX_IDLE  = 0;
  localparam int UART_STAT_RX_VALID = 1;
  localparam int UART_STAT_OVERRUN  = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + baud / 2) / baud;
    return d < 4 ? 4 : d;
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: rxd synchronizer and 8N1 receive FSM producing a byte with a one-cycle valid strobe
module uart_rx_core
  import uart_controller_pkg::*;
#(
  parameter int DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  logic s1, s2;
  logic [1:0] st;
  logic [CW-1:0] cnt;
  logic [2:0] bitc;
  // rx_byte doubles as the shift register; it is only meaningful while rx_valid pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      st <= ST_IDLE;
      cnt <= '0;
      bitc <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      rx_valid <= 1'b0;
      if (st == ST_IDLE) begin
        if (!s2) begin
          st <= ST_START;
          cnt <= HALF;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        cnt <= FULL;
        if (st == ST_START) begin
          st <= s2 ? ST_IDLE : ST_DATA;
          bitc <= '0;
        end else if (st == ST_DATA) begin
          rx_byte <= {s2, rx_byte[7:1]};
          bitc <= bitc + 3'd1;
          if (bitc == 3'd7) st <= ST_STOP;
        end else begin
          rx_valid <= s2;
          st <= ST_IDLE;
        end
      end
    end
  end
endmodule

// File: rtl/uart_controller.sv
// uart_controller: bus-mapped UART with one-byte TX holding, one-byte RX buffer and 8N1 framing
module uart_controller
  import uart_controller_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] data_wr,
  input  logic [3:0]  mask,
  output logic [31:0] data_rd,
  output logic [31:0] data_rd_2,
  output logic        stall,
  output logic        txd,
  input  logic        rxd
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  logic [1:0] tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic tx_idle, wr_data, accept, pop, rd_en;
  logic [7:0] rx_byte, rx_buf;
  logic rx_strobe, rx_valid, overrun;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = ^{address[31:3], address[1:0], data_wr[31:8], mask[3:1]};
  assign data_rd_2 = '0;
  assign tx_idle = tx_st == ST_IDLE;
  assign wr_data = write && mask[0] && address[2] == UART_REG_DATA;
  assign stall = wr_data && !tx_idle;
  assign accept = wr_data && tx_idle;
  assign rd_en = read && !write;
  assign pop = rd_en && address[2] == UART_REG_DATA;
  always_comb begin
    status = '0;
    status[UART_STAT_TX_IDLE] = tx_idle;
    status[UART_STAT_RX_VALID] = rx_valid;
    status[UART_STAT_OVERRUN] = overrun;
    data_rd = !rd_en ? '0 : address[2] == UART_REG_STATUS ? status : rx_valid ? {24'b0, rx_buf} : '0;
  end
  // txd is registered so every bit, including start, lasts exactly DIV cycles from the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= ST_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      txd <= 1'b1;
    end else if (tx_idle) begin
      if (accept) begin
        tx_st <= ST_START;
        tx_cnt <= FULL;
        tx_sh <= data_wr[7:0];
        txd <= 1'b0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - CW'(1);
    end else begin
      tx_cnt <= FULL;
      if (tx_st == ST_START) begin
        tx_st <= ST_DATA;
        tx_bit <= '0;
        txd <= tx_sh[0];
        tx_sh <= tx_sh >> 1;
      end else if (tx_st == ST_DATA) begin
        tx_bit <= tx_bit + 3'd1;
        txd <= tx_bit == 3'd7 ? 1'b1 : tx_sh[0];
        tx_sh <= tx_sh >> 1;
        if (tx_bit == 3'd7) tx_st <= ST_STOP;
      end else begin
        tx_st <= ST_IDLE;
      end
    end
  end
  // an arriving byte beats a simultaneous pop; overrun only when an unread byte is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf <= '0;
      rx_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (rx_strobe) begin
      rx_buf <= rx_byte;
      rx_valid <= 1'b1;
      overrun <= rx_valid && !pop;
    end else if (pop) begin
      rx_valid <= 1'b0;
      overrun <= 1'b0;
    end
  end
  uart_rx_core #(.DIV(DIV)) u_rx (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .rx_byte(rx_byte),
    .rx_valid(rx_strobe)
  );
endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: directed self-checking bench for uart_controller with DIV=8
module tb_uart_controller;
  logic clk = 1'b0, rst = 1'b1, read = 1'b0, write = 1'b0, rxd = 1'b1;
  logic [31:0] address = '0, data_wr = '0;
  logic [3:0] mask = '0;
  logic [31:0] data_rd, data_rd_2;
  logic stall, txd;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  uart_controller #(.CLK_HZ(921600), .BAUD(115200)) dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .data_wr(data_wr), .mask(mask), .data_rd(data_rd), .data_rd_2(data_rd_2),
    .stall(stall), .txd(txd), .rxd(rxd)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_read(input logic a, output logic [31:0] d);
    address = {29'b0, a, 2'b00};
    read = 1'b1;
    #1;
    d = data_rd;
    step();
    read = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] b, output int n);
    address = '0;
    data_wr = {24'b0, b};
    mask = 4'h1;
    write = 1'b1;
    #1;
    n = 0;
    while (stall && n < 300) begin
      step();
      n++;
    end
    step();
    write = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (8) step();
    end
    rxd = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) step();
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b want 1", txd); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++; if (data_rd !== 32'h0) begin n_fail++; $display("FAIL reset_data_rd got %h want 0", data_rd); end
    n_checks++; if (data_rd_2 !== 32'h0) begin n_fail++; $display("FAIL reset_data_rd_2 got %h want 0", data_rd_2); end
    rst = 1'b0;
    step();
    do_read(1'b1, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL reset_status got %h want 1", d); end
    do_read(1'b0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", d); end
  endtask

  task automatic test_tx_single();
    int n;
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    do_write(8'h55, n);
    n_checks++; if (n !== 0) begin n_fail++; $display("FAIL tx1_stall_cycles got %0d want 0", n); end
    address = 32'h4;
    read = 1'b1;
    #1;
    for (int c = 0; c < 80; c++) begin
      n_checks++; if (txd !== frame[c/8]) begin n_fail++; $display("FAIL tx1_txd cycle %0d got %b want %b", c, txd, frame[c/8]); end
      n_checks++; if (data_rd !== 32'h0) begin n_fail++; $display("FAIL tx1_status_busy cycle %0d got %h want 0", c, data_rd); end
      step();
    end
    n_checks++; if (data_rd !== 32'h1) begin n_fail++; $display("FAIL tx1_status_done got %h want 1", data_rd); end
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL tx1_txd_idle got %b want 1", txd); end
    read = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    logic [9:0] frame;
    frame = {1'b1, 8'h42, 1'b0};
    do_write(8'h41, n1);
    n_checks++; if (n1 !== 0) begin n_fail++; $display("FAIL b2b_first_stall got %0d want 0", n1); end
    do_write(8'h42, n2);
    n_checks++; if (n2 !== 80) begin n_fail++; $display("FAIL b2b_second_stall got %0d want 80", n2); end
    for (int c = 0; c < 80; c++) begin
      n_checks++; if (txd !== frame[c/8]) begin n_fail++; $display("FAIL b2b_txd cycle %0d got %b want %b", c, txd, frame[c/8]); end
      step();
    end
    step();
  endtask

  task automatic test_rx_single();
    logic [31:0] d;
    send_rx(8'hA3, 1'b1);
    do_read(1'b1, d);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL rx1_status got %h want 3", d); end
    do_read(1'b0, d);
    n_checks++; if (d !== 32'hA3) begin n_fail++; $display("FAIL rx1_data got %h want a3", d); end
    do_read(1'b1, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL rx1_status_after got %h want 1", d); end
    do_read(1'b0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx1_data_empty got %h want 0", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    do_read(1'b1, d);
    n_checks++; if (d !== 32'h7) begin n_fail++; $display("FAIL ovr_status got %h want 7", d); end
    do_read(1'b0, d);
    n_checks++; if (d !== 32'h22) begin n_fail++; $display("FAIL ovr_data got %h want 22", d); end
    do_read(1'b1, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL ovr_status_after got %h want 1", d); end
  endtask

  task automatic test_glitch_framing();
    logic [31:0] d;
    rxd = 1'b0;
    repeat (3) step();
    rxd = 1'b1;
    repeat (12) step();
    do_read(1'b1, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL glitch_status got %h want 1", d); end
    send_rx(8'h5A, 1'b0);
    repeat (20) step();
    do_read(1'b1, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL framing_status got %h want 1", d); end
    do_read(1'b0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL framing_data got %h want 0", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    send_rx(8'h3C, 1'b1);
    address = 32'h4;
    data_wr = '0;
    mask = 4'h1;
    read = 1'b1;
    write = 1'b1;
    #1;
    n_checks++; if (data_rd !== 32'h0) begin n_fail++; $display("FAIL prio_data_rd got %h want 0", data_rd); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL prio_stall got %b want 0", stall); end
    step();
    read = 1'b0;
    write = 1'b0;
    do_read(1'b1, d);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL prio_status got %h want 3", d); end
    do_read(1'b0, d);
    n_checks++; if (d !== 32'h3C) begin n_fail++; $display("FAIL prio_data got %h want 3c", d); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    logic [31:0] d;
    logic [9:0] frame;
    frame = {1'b1, 8'h96, 1'b0};
    do_write(8'hF0, n);
    repeat (20) step();
    n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL rstmid_txd_before got %b want 0", txd); end
    rst = 1'b1;
    step();
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL rstmid_txd_after got %b want 1", txd); end
    rst = 1'b0;
    do_read(1'b1, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL rstmid_status got %h want 1", d); end
    do_write(8'h96, n);
    n_checks++; if (n !== 0) begin n_fail++; $display("FAIL rstmid_stall got %0d want 0", n); end
    for (int c = 0; c < 80; c++) begin
      n_checks++; if (txd !== frame[c/8]) begin n_fail++; $display("FAIL rstmid_txd cycle %0d got %b want %b", c, txd, frame[c/8]); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_single();
    test_overrun();
    test_glitch_framing();
    test_priority();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
